// File: rtl/vga_pkg.sv
// Shared VGA pipeline definitions: sprite geometry, bus widths, and the timing bundle
// that travels alongside every pixel.
package vga_pkg;

   localparam int IMG_W  = 64;
   localparam int IMG_H  = 64;
   localparam int ADDR_W = 12;
   localparam int RGB_W  = 12;
   localparam int CNT_W  = 11;

   typedef struct packed {
      logic [CNT_W-1:0] hcount;
      logic [CNT_W-1:0] vcount;
      logic             hsync;
      logic             vsync;
      logic             hblnk;
      logic             vblnk;
   } vga_timing_t;

   // 13-bit compare so that a sprite origin near 4095 cannot wrap its end bound.
   function automatic logic in_span(input logic [CNT_W-1:0] c,
                                    input logic [11:0]      lo,
                                    input logic [12:0]      len);
      logic [12:0] c13;
      logic [12:0] lo13;
      c13  = {2'b00, c};
      lo13 = {1'b0, lo};
      return (c13 >= lo13) && (c13 < (lo13 + len));
   endfunction

endpackage

// File: rtl/delay.sv
// Fixed-depth shift register with synchronous active-high reset, used to keep
// side-band data aligned with the sprite ROM read.
module delay #(
   parameter int WIDTH = 1,
   parameter int DEPTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   logic [WIDTH-1:0] r_pipe [DEPTH];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) r_pipe[i] <= '0;
      end else begin
         r_pipe[0] <= din;
         for (int i = 1; i < DEPTH; i++) r_pipe[i] <= r_pipe[i-1];
      end
   end

   assign dout = r_pipe[DEPTH-1];

endmodule

// File: rtl/draw_cat.sv
// Composites the 64x64 cat sprite over the incoming VGA stream. The sprite ROM sits
// outside this block and returns data one clock after pixel_addr; all outputs lag by 3.
module draw_cat
   import vga_pkg::*;
#(
   parameter logic [RGB_W-1:0] KEY_COLOR = 12'hF0F,
   parameter bit               KEY_EN    = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [11:0]       xpos,
   input  logic [11:0]       ypos,
   input  logic [CNT_W-1:0]  hcount_in,
   input  logic [CNT_W-1:0]  vcount_in,
   input  logic              hsync_in,
   input  logic              vsync_in,
   input  logic              hblnk_in,
   input  logic              vblnk_in,
   input  logic [RGB_W-1:0]  rgb_in,
   output logic [ADDR_W-1:0] pixel_addr,
   input  logic [RGB_W-1:0]  rgb_pixel,
   output logic [CNT_W-1:0]  hcount_out,
   output logic [CNT_W-1:0]  vcount_out,
   output logic              hsync_out,
   output logic              vsync_out,
   output logic              hblnk_out,
   output logic              vblnk_out,
   output logic [RGB_W-1:0]  rgb_out
);

   localparam int BUNDLE_W = $bits(vga_timing_t) + RGB_W + 1;

   logic [11:0]         r_xpos;
   logic [11:0]         r_ypos;
   logic                r_vblnk_prev;

   logic [5:0]          w_rel_x;
   logic [5:0]          w_rel_y;
   logic                w_inside;
   vga_timing_t         w_timing_in;
   vga_timing_t         w_timing_d2;
   logic [RGB_W-1:0]    w_rgb_d2;
   logic                w_inside_d2;
   logic [BUNDLE_W-1:0] w_bundle_in;
   logic [BUNDLE_W-1:0] w_bundle_d2;
   logic                w_keyed;
   logic                w_draw;

   // Position is sampled only at the start of vertical blanking so a frame never tears.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_xpos       <= '0;
         r_ypos       <= '0;
         r_vblnk_prev <= 1'b0;
      end else begin
         r_vblnk_prev <= vblnk_in;
         if (vblnk_in && !r_vblnk_prev) begin
            r_xpos <= xpos;
            r_ypos <= ypos;
         end
      end
   end

   // Low six bits of the 13-bit difference equal the difference of the low six bits.
   assign w_rel_x  = hcount_in[5:0] - r_xpos[5:0];
   assign w_rel_y  = vcount_in[5:0] - r_ypos[5:0];
   assign w_inside = in_span(hcount_in, r_xpos, 13'(IMG_W)) &&
                     in_span(vcount_in, r_ypos, 13'(IMG_H));

   always_ff @(posedge clk) begin
      if (rst) pixel_addr <= '0;
      else     pixel_addr <= {w_rel_y, w_rel_x};
   end

   assign w_timing_in = '{hcount: hcount_in, vcount: vcount_in,
                          hsync:  hsync_in,  vsync:  vsync_in,
                          hblnk:  hblnk_in,  vblnk:  vblnk_in};
   assign w_bundle_in = {w_timing_in, rgb_in, w_inside};

   delay #(.WIDTH(BUNDLE_W), .DEPTH(2)) u_delay (
      .clk  (clk),
      .rst  (rst),
      .din  (w_bundle_in),
      .dout (w_bundle_d2)
   );

   assign {w_timing_d2, w_rgb_d2, w_inside_d2} = w_bundle_d2;

   assign w_keyed = KEY_EN && (rgb_pixel == KEY_COLOR);
   assign w_draw  = w_inside_d2 && !(w_timing_d2.hblnk || w_timing_d2.vblnk) && !w_keyed;

   always_ff @(posedge clk) begin
      if (rst) begin
         hcount_out <= '0;
         vcount_out <= '0;
         hsync_out  <= 1'b0;
         vsync_out  <= 1'b0;
         hblnk_out  <= 1'b0;
         vblnk_out  <= 1'b0;
         rgb_out    <= '0;
      end else begin
         hcount_out <= w_timing_d2.hcount;
         vcount_out <= w_timing_d2.vcount;
         hsync_out  <= w_timing_d2.hsync;
         vsync_out  <= w_timing_d2.vsync;
         hblnk_out  <= w_timing_d2.hblnk;
         vblnk_out  <= w_timing_d2.vblnk;
         rgb_out    <= w_draw ? rgb_pixel : w_rgb_d2;
      end
   end

endmodule

// File: tb/tb_draw_cat.sv
// Directed bench for draw_cat: two instances (colour key on/off) share one stimulus
// stream, each fed by its own one-clock-latency ROM model.
module tb_draw_cat;

   logic        clk = 1'b0;
   logic        rst;
   logic [11:0] xpos, ypos;
   logic [10:0] hcount_in, vcount_in;
   logic        hsync_in, vsync_in, hblnk_in, vblnk_in;
   logic [11:0] rgb_in;

   logic [11:0] pixel_addr, rgb_pixel;
   logic [10:0] hcount_out, vcount_out;
   logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
   logic [11:0] rgb_out;

   logic [11:0] nk_pixel_addr, nk_rgb_pixel;
   logic [10:0] nk_hcount_out, nk_vcount_out;
   logic        nk_hsync_out, nk_vsync_out, nk_hblnk_out, nk_vblnk_out;
   logic [11:0] nk_rgb_out;

   logic        rom_key;
   int          total = 0;
   int          bad   = 0;

   always #5 clk = ~clk;

   draw_cat u_dut (
      .clk(clk), .rst(rst), .xpos(xpos), .ypos(ypos),
      .hcount_in(hcount_in), .vcount_in(vcount_in),
      .hsync_in(hsync_in), .vsync_in(vsync_in), .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
      .rgb_in(rgb_in), .pixel_addr(pixel_addr), .rgb_pixel(rgb_pixel),
      .hcount_out(hcount_out), .vcount_out(vcount_out),
      .hsync_out(hsync_out), .vsync_out(vsync_out), .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
      .rgb_out(rgb_out)
   );

   draw_cat #(.KEY_EN(1'b0)) u_dut_nokey (
      .clk(clk), .rst(rst), .xpos(xpos), .ypos(ypos),
      .hcount_in(hcount_in), .vcount_in(vcount_in),
      .hsync_in(hsync_in), .vsync_in(vsync_in), .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
      .rgb_in(rgb_in), .pixel_addr(nk_pixel_addr), .rgb_pixel(nk_rgb_pixel),
      .hcount_out(nk_hcount_out), .vcount_out(nk_vcount_out),
      .hsync_out(nk_hsync_out), .vsync_out(nk_vsync_out), .hblnk_out(nk_hblnk_out),
      .vblnk_out(nk_vblnk_out), .rgb_out(nk_rgb_out)
   );

   // ROM models: data is the address itself, or the key colour when rom_key is set.
   always @(posedge clk) begin
      rgb_pixel    <= rom_key ? 12'hF0F : pixel_addr;
      nk_rgb_pixel <= rom_key ? 12'hF0F : nk_pixel_addr;
   end

   task automatic push(input int h, input int v, input logic [11:0] rgb,
                       input logic hb, input logic vb, input logic hs);
      hcount_in = 11'(h);
      vcount_in = 11'(v);
      rgb_in    = rgb;
      hblnk_in  = hb;
      vblnk_in  = vb;
      hsync_in  = hs;
      @(posedge clk);
      #1;
   endtask

   task automatic new_frame(input int x, input int y);
      xpos = 12'(x);
      ypos = 12'(y);
      push(0, 600, 12'h000, 1'b0, 1'b1, 1'b0);
      push(0, 0, 12'h000, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      push(123, 45, 12'h5A5, 1'b1, 1'b1, 1'b1);
      push(124, 45, 12'h5A6, 1'b1, 1'b1, 1'b1);
      total++;
      if ({rgb_out, hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out,
           pixel_addr} !== '0) begin
         bad++;
         $display("FAIL reset_state: rgb=%h h=%0d v=%0d addr=%h, required all zero",
                  rgb_out, hcount_out, vcount_out, pixel_addr);
      end
      rst = 1'b0;
      push(0, 0, 12'h000, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_basic_draw();
      new_frame(100, 50);
      push(100, 50, 12'h123, 1'b0, 1'b0, 1'b0);
      total++;
      if (pixel_addr !== 12'h000) begin
         bad++; $display("FAIL addr_topleft: got %h required 000", pixel_addr);
      end
      push(163, 113, 12'h456, 1'b0, 1'b0, 1'b0);
      total++;
      if (pixel_addr !== 12'hFFF) begin
         bad++; $display("FAIL addr_botright: got %h required fff", pixel_addr);
      end
      push(164, 50, 12'hABC, 1'b0, 1'b0, 1'b0);
      total++;
      if (rgb_out !== 12'h000 || hcount_out !== 11'd100 || vcount_out !== 11'd50) begin
         bad++;
         $display("FAIL draw_topleft: rgb=%h h=%0d v=%0d required 000/100/50",
                  rgb_out, hcount_out, vcount_out);
      end
      push(99, 50, 12'h321, 1'b0, 1'b0, 1'b0);
      total++;
      if (rgb_out !== 12'hFFF) begin
         bad++; $display("FAIL draw_botright: got %h required fff", rgb_out);
      end
      push(110, 60, 12'h777, 1'b0, 1'b0, 1'b0);
      total++;
      if (rgb_out !== 12'hABC || pixel_addr !== 12'h28A) begin
         bad++;
         $display("FAIL right_edge: rgb=%h addr=%h required abc/28a", rgb_out, pixel_addr);
      end
      push(0, 0, 12'h000, 1'b0, 1'b0, 1'b0);
      total++;
      if (rgb_out !== 12'h321) begin
         bad++; $display("FAIL left_edge: got %h required 321", rgb_out);
      end
      push(0, 0, 12'h000, 1'b0, 1'b0, 1'b0);
      total++;
      if (rgb_out !== 12'h28A) begin
         bad++; $display("FAIL draw_mid: got %h required 28a", rgb_out);
      end
   endtask

   task automatic test_latency();
      for (int i = 0; i < 8; i++) begin
         push(500 + i, 300, 12'(i), (i == 4), 1'b0, (i >= 3));
         if (i >= 2) begin
            total++;
            if (hcount_out !== 11'(500 + i - 2) || hsync_out !== (i - 2 >= 3) ||
                hblnk_out !== (i - 2 == 4) || rgb_out !== 12'(i - 2)) begin
               bad++;
               $display("FAIL latency_%0d: h=%0d hs=%b hb=%b rgb=%h required h=%0d hs=%b hb=%b rgb=%h",
                        i, hcount_out, hsync_out, hblnk_out, rgb_out,
                        500 + i - 2, (i - 2 >= 3), (i - 2 == 4), 12'(i - 2));
            end
         end
      end
   endtask

   task automatic test_color_key();
      rom_key = 1'b1;
      push(120, 70, 12'h5A5, 1'b0, 1'b0, 1'b0);
      push(0, 0, 12'h000, 1'b0, 1'b0, 1'b0);
      push(0, 0, 12'h000, 1'b0, 1'b0, 1'b0);
      total++;
      if (rgb_out !== 12'h5A5) begin
         bad++; $display("FAIL key_on: got %h required 5a5", rgb_out);
      end
      total++;
      if (nk_rgb_out !== 12'hF0F) begin
         bad++; $display("FAIL key_off: got %h required f0f", nk_rgb_out);
      end
      rom_key = 1'b0;
   endtask

   task automatic test_frame_sync();
      xpos = 12'd200;
      push(100, 50, 12'h111, 1'b0, 1'b0, 1'b0);
      push(200, 50, 12'h222, 1'b0, 1'b0, 1'b0);
      push(0, 0, 12'h000, 1'b0, 1'b0, 1'b0);
      total++;
      if (rgb_out !== 12'h000) begin
         bad++; $display("FAIL old_pos_draws: got %h required 000", rgb_out);
      end
      push(0, 0, 12'h000, 1'b0, 1'b0, 1'b0);
      total++;
      if (rgb_out !== 12'h222) begin
         bad++; $display("FAIL new_pos_early: got %h required 222", rgb_out);
      end
      new_frame(200, 50);
      push(200, 50, 12'h333, 1'b0, 1'b0, 1'b0);
      push(100, 50, 12'h111, 1'b0, 1'b0, 1'b0);
      push(0, 0, 12'h000, 1'b0, 1'b0, 1'b0);
      total++;
      if (rgb_out !== 12'h000) begin
         bad++; $display("FAIL new_pos_draws: got %h required 000", rgb_out);
      end
      push(0, 0, 12'h000, 1'b0, 1'b0, 1'b0);
      total++;
      if (rgb_out !== 12'h111) begin
         bad++; $display("FAIL old_pos_gone: got %h required 111", rgb_out);
      end
   endtask

   task automatic test_clip_blank();
      new_frame(780, 50);
      push(790, 50, 12'h0AA, 1'b0, 1'b0, 1'b0);
      total++;
      if (pixel_addr !== 12'h00A) begin
         bad++; $display("FAIL clip_addr: got %h required 00a", pixel_addr);
      end
      push(5, 50, 12'h0BB, 1'b0, 1'b0, 1'b0);
      push(795, 50, 12'h0CC, 1'b1, 1'b0, 1'b0);
      total++;
      if (rgb_out !== 12'h00A) begin
         bad++; $display("FAIL clip_draw: got %h required 00a", rgb_out);
      end
      push(799, 113, 12'h0EE, 1'b0, 1'b0, 1'b0);
      total++;
      if (rgb_out !== 12'h0BB) begin
         bad++; $display("FAIL no_wrap: got %h required 0bb", rgb_out);
      end
      push(0, 0, 12'h000, 1'b0, 1'b0, 1'b0);
      total++;
      if (rgb_out !== 12'h0CC) begin
         bad++; $display("FAIL blank_passthru: got %h required 0cc", rgb_out);
      end
      push(0, 0, 12'h000, 1'b0, 1'b0, 1'b0);
      total++;
      if (rgb_out !== 12'hFD3) begin
         bad++; $display("FAIL clip_corner: got %h required fd3", rgb_out);
      end
      new_frame(4000, 0);
      push(2047, 10, 12'h0DD, 1'b0, 1'b0, 1'b0);
      push(0, 0, 12'h000, 1'b0, 1'b0, 1'b0);
      push(0, 0, 12'h000, 1'b0, 1'b0, 1'b0);
      total++;
      if (rgb_out !== 12'h0DD) begin
         bad++; $display("FAIL offscreen: got %h required 0dd", rgb_out);
      end
   endtask

   task automatic test_reset_mid();
      new_frame(100, 50);
      push(300, 300, 12'h999, 1'b0, 1'b0, 1'b1);
      rst = 1'b1;
      for (int i = 0; i < 2; i++) begin
         push(301 + i, 300, 12'h998, 1'b1, 1'b1, 1'b1);
         total++;
         if ({rgb_out, hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out,
              pixel_addr} !== '0) begin
            bad++;
            $display("FAIL reset_hold_%0d: rgb=%h h=%0d v=%0d hs=%b addr=%h required all zero",
                     i, rgb_out, hcount_out, vcount_out, hsync_out, pixel_addr);
         end
      end
      rst = 1'b0;
      push(10, 5, 12'h345, 1'b0, 1'b0, 1'b0);
      total++;
      if (pixel_addr !== 12'h14A || rgb_out !== 12'h000) begin
         bad++;
         $display("FAIL reset_release: addr=%h rgb=%h required 14a/000", pixel_addr, rgb_out);
      end
      push(0, 0, 12'h000, 1'b0, 1'b0, 1'b0);
      push(0, 0, 12'h000, 1'b0, 1'b0, 1'b0);
      total++;
      if (rgb_out !== 12'h14A || hcount_out !== 11'd10 || vcount_out !== 11'd5) begin
         bad++;
         $display("FAIL reset_pos_origin: rgb=%h h=%0d v=%0d required 14a/10/5",
                  rgb_out, hcount_out, vcount_out);
      end
   endtask

   initial begin
      rom_key  = 1'b0;
      rst      = 1'b1;
      xpos     = '0;
      ypos     = '0;
      vsync_in = 1'b0;
      test_reset();
      test_basic_draw();
      test_latency();
      test_color_key();
      test_frame_sync();
      test_clip_blank();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/draw_cat.md
# draw_cat

Overlays the 64×64 cat sprite onto the VGA pixel stream, directly upstream of the `cat_image` ROM. It converts the incoming pixel coordinates into a ROM address, `{rel_y[5:0], rel_x[5:0]}`, and consumes the ROM's 12-bit pixel one clock later. It re-aligns all timing signals to the ROM latency and emits the composited stream to the next drawing stage or the VGA output. The sprite position is frame-synchronous, so it never tears mid-frame.

## Interface
Parameters:
- `KEY_COLOR`, default 12'hF0F: sprite colour treated as transparent.
- `KEY_EN`, default 1: 1 enables colour-key transparency; 0 draws every sprite pixel.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  pixel clock.
- `rst`  in  1  synchronous, active-high reset.
- `xpos`  in  12  requested sprite left column; asynchronous to the frame.
- `ypos`  in  12  requested sprite top row.
- `hcount_in`, `vcount_in`  in  11 each  current pixel coordinates.
- `hsync_in`, `vsync_in`, `hblnk_in`, `vblnk_in`  in  1 each  timing from the upstream stage.
- `rgb_in`  in  12  background pixel.
- `pixel_addr`  out  12  ROM address, registered: `{rel_y[5:0], rel_x[5:0]}`.
- `rgb_pixel`  in  12  ROM data. Valid one clock after `pixel_addr`.
- `hcount_out`, `vcount_out`  out  11 each  delayed coordinates.
- `hsync_out`, `vsync_out`, `hblnk_out`, `vblnk_out`  out  1 each  delayed timing.
- `rgb_out`  out  12  composited pixel.

## Operation
- **Position latch.** `xpos_r`/`ypos_r` load `xpos`/`ypos` only on the rising edge of `vblnk_in`, detected against a registered `vblnk_prev`. Otherwise they hold. Reset values: `xpos_r` = 0, `ypos_r` = 0, `vblnk_prev` = 0.
- **Relative coordinates.** `rel_x = hcount_in − xpos_r` and `rel_y = vcount_in − ypos_r`, computed in 13 bits. `pixel_addr` takes the low 6 bits of each.
- **Inside test.** `inside` = (`hcount_in` ≥ `xpos_r`) AND (`hcount_in` < `xpos_r`+64) AND (`vcount_in` ≥ `ypos_r`) AND (`vcount_in` < `ypos_r`+64).
  - All comparisons are 13-bit unsigned, so `xpos_r`+64 never wraps.
  - A sprite partly off-screen is clipped naturally.
  - A sprite fully off-screen (for example `xpos_r` = 4000) never draws.
- **Stage 1** (edge k): register `pixel_addr`, `inside`, and the timing/`rgb_in` bundle.
- **Stage 2** (edge k+1): the ROM registers its data. `inside` and the bundle are delayed once more.
- **Stage 3** (edge k+2): register the outputs.
  - `rgb_out` = `rgb_pixel` when `inside_d2` AND NOT (`hblnk_d2` OR `vblnk_d2`) AND NOT (`KEY_EN` AND `rgb_pixel` == `KEY_COLOR`).
  - Otherwise `rgb_out` = `rgb_in_d2`.
- `pixel_addr` keeps toggling outside the sprite; its value there is don't-care.
- **Reset.** Every register, including every output and `pixel_addr`, clears to 0.
  - If `rst` is asserted mid-frame, outputs read 0 from the next edge and stay 0 while `rst` is high.
  - After release, the first three output cycles carry zero-valued pipeline contents. From then on, outputs track the inputs.
  - The latched position restarts at 0,0 until the next `vblnk_in` rise.

## Timing
- Latency is exactly 3 clocks for every output. An input sampled at edge k appears on the outputs after edge k+2.
- This holds for the timing, coordinate and `rgb` bundle alike, so the sync/rgb alignment from upstream is preserved.
- `pixel_addr` has latency 1. The ROM read latency must equal 1; any other ROM latency is not supported.
- Position update takes effect from the first pixel after the `vblnk_in` rising edge. A new position that arrives in the same cycle as that edge is captured.
- There is no back-pressure; the block accepts one pixel every clock.

## Structure
- Shared package `vga_pkg` holds:
  - `IMG_W` = 64 and `IMG_H` = 64;
  - `ADDR_W` = 12, `RGB_W` = 12, `CNT_W` = 11;
  - a packed typedef `vga_timing_t` covering hcount, vcount, hsync, vsync, hblnk and vblnk.
- One natural sub-module, `delay`, parameterised by `WIDTH` and `DEPTH` with synchronous-reset registers. It carries `vga_timing_t`, `rgb` and `inside` through the three stages.

## Test plan
- **Basic draw.** Reset, then `xpos` = 100, `ypos` = 50, one frame of 800×600 timing, ROM model returns `rgb_pixel` = `pixel_addr`. Pixel (100,50) gives `pixel_addr` = 12'h000 and `rgb_out` = 12'h000 three clocks later. Pixel (163,113) gives `pixel_addr` = 12'hFFF. Pixel (164,50) gives `rgb_out` = `rgb_in`.
- **Latency.** Toggle `hsync_in` at a known edge. `hsync_out` changes exactly 3 edges later. `hcount_out` equals `hcount_in` delayed by 3 edges throughout.
- **Colour key.** ROM returns 12'hF0F inside the sprite, so `rgb_out` = `rgb_in`. Rerun with `KEY_EN` = 0, so `rgb_out` = 12'hF0F.
- **Frame-sync position.** Change `xpos` to 200 mid-frame: the current frame still draws at 100. After the `vblnk_in` rise, the next frame draws at 200.
- **Clipping and blanking.** `xpos` = 780: only columns 780–799 draw, and no wrap to column 0. Sprite pixels falling in the blanking interval give `rgb_out` = `rgb_in`.
- **Reset mid-frame.** Assert `rst` for 2 clocks mid-line: all outputs are 0 while held. Outputs return to tracking the inputs 3 clocks after release. The sprite stays at 0,0 until the next `vblnk_in` rise.
